// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback path: request record and grant source.
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Load-response FIFO: wrap-around pointers plus occupancy count, head visible combinationally
// so the arbiter can pop and forward it in the same cycle.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type req_t = wb_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  req_t din,
  input  logic pop,
  output req_t head,
  output logic full,
  output logic empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset: a flush only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/reg_writeback.sv
// Merges ALU results and buffered load responses onto the single register-file write port,
// with a bounded-wait arbiter so continuous ALU traffic cannot starve loads.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  mem_ready,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  busy
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } req_t;

  req_t                  mem_req;
  req_t                  head;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  mem_prio;
  logic [WAIT_W-1:0]     wait_cnt;
  wb_src_e               grant;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  assign mem_req = '{rd: mem_rd, data: mem_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .req_t (req_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (mem_req),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign mem_ready = !full;
  assign busy      = !empty;
  assign push      = mem_valid && !full;
  assign mem_prio  = !empty && ((wait_cnt == WAIT_W'(MAX_WAIT)) || full);
  assign alu_ready = !mem_prio;

  always_comb begin
    grant    = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (mem_prio || (!alu_valid && !empty)) begin
      grant    = SRC_MEM;
      sel_rd   = head.rd;
      sel_data = head.data;
    end else if (alu_valid) begin
      grant    = SRC_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  assign pop = (grant == SRC_MEM);

  // The head's patience counter restarts whenever it is served or there is no head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (empty || pop) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen   <= (grant != SRC_NONE) && (sel_rd != '0);
      rf_waddr <= sel_rd;
      rf_wdata <= sel_data;
    end
  end
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: reset, ALU path, x0, starvation bound, full FIFO,
// simultaneous push/pop and mid-operation asynchronous reset.
module tb_reg_writeback;
  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  reg_writeback #(.XLEN(32), .FIFO_DEPTH(4), .MAX_WAIT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen got %b want 0", rf_wen); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr got %0d want 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata got %h want 0", rf_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got %b want 1", mem_ready); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %b want 1", alu_ready); end
    $display("reset: rf_wen=%b busy=%b mem_ready=%b alu_ready=%b", rf_wen, busy, mem_ready, alu_ready);
    #10 rst = 0;
    step();
  endtask

  task automatic test_alu_basic();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_basic_ready got %b want 1", alu_ready); end
    step();
    idle_inputs();
    checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL alu_basic_wen got %b want 1", rf_wen); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_basic_waddr got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_basic_wdata got %h want deadbeef", rf_wdata); end
    $display("alu_basic: wen=%b waddr=%0d wdata=%h", rf_wen, rf_waddr, rf_wdata);
    step();
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL alu_basic_idle_wen got %b want 0", rf_wen); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL alu_basic_idle_waddr got %0d want 0", rf_waddr); end
  endtask

  task automatic test_alu_x0();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_x0_ready got %b want 1", alu_ready); end
    step();
    idle_inputs();
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL alu_x0_wen got %b want 0", rf_wen); end
    checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL alu_x0_wdata got %h want 1234", rf_wdata); end
    $display("alu_x0: wen=%b waddr=%0d wdata=%h", rf_wen, rf_waddr, rf_wdata);
    step();
  endtask

  task automatic test_starvation();
    alu_valid = 1; alu_rd = 10; alu_data = 32'hA0;
    mem_valid = 1; mem_rd = 7; mem_data = 32'hCAFE0007;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL starve_mem_ready got %b want 1", mem_ready); end
    step();
    mem_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      alu_rd = 5'(10 + c); alu_data = 32'(32'hA0 + c);
      checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(10 + c - 1)) begin
        errors++; $display("FAIL starve_alu_write c%0d got wen=%b waddr=%0d want wen=1 waddr=%0d", c, rf_wen, rf_waddr, 10 + c - 1);
      end
      checks++; if (alu_ready !== (c < 4)) begin
        errors++; $display("FAIL starve_alu_ready c%0d got %b want %b", c, alu_ready, c < 4);
      end
      $display("starve c%0d: alu_ready=%b wen=%b waddr=%0d busy=%b", c, alu_ready, rf_wen, rf_waddr, busy);
      step();
    end
    alu_valid = 0;
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hCAFE0007) begin
      errors++; $display("FAIL starve_load_write got wen=%b waddr=%0d wdata=%h want 1/7/cafe0007", rf_wen, rf_waddr, rf_wdata);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_busy got %b want 0", busy); end
    $display("starve c5: wen=%b waddr=%0d wdata=%h", rf_wen, rf_waddr, rf_wdata);
    step();
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL starve_tail_wen got %b want 0", rf_wen); end
  endtask

  task automatic test_full();
    for (int c = 0; c < 4; c++) begin
      alu_valid = 1; alu_rd = 5'(20 + c); alu_data = 32'(c);
      mem_valid = 1; mem_rd = 5'(11 + c); mem_data = 32'(32'hF00 + c);
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready c%0d got %b want 1", c, mem_ready); end
      $display("full push c%0d: rd=%0d mem_ready=%b", c, mem_rd, mem_ready);
      step();
    end
    idle_inputs();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL full_mem_ready got %b want 0", mem_ready); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL full_alu_ready got %b want 0", alu_ready); end
    checks++; if (rf_waddr !== 5'd23) begin errors++; $display("FAIL full_last_alu got %0d want 23", rf_waddr); end
    step();
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b want 1", mem_ready); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(11 + k) || rf_wdata !== 32'(32'hF00 + k)) begin
        errors++; $display("FAIL full_drain k%0d got wen=%b waddr=%0d wdata=%h want 1/%0d/%h", k, rf_wen, rf_waddr, rf_wdata, 11 + k, 32'hF00 + k);
      end
      $display("full drain k%0d: wen=%b waddr=%0d wdata=%h", k, rf_wen, rf_waddr, rf_wdata);
      step();
    end
    checks++; if (rf_wen !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL full_after_drain got wen=%b busy=%b want 0/0", rf_wen, busy);
    end
  endtask

  task automatic test_push_pop();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_rd = 25; alu_data = 32'h25;
      mem_valid = 1; mem_rd = 5'(16 + c); mem_data = 32'(32'hB00 + c);
      step();
    end
    alu_valid = 0;
    mem_valid = 1; mem_rd = 19; mem_data = 32'hB03;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL pp_ready_occ3 got %b want 1", mem_ready); end
    step();
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        mem_valid = 1; mem_rd = 20; mem_data = 32'hB04;
      end else begin
        mem_valid = 0;
      end
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL pp_ready k%0d got %b want 1", k, mem_ready); end
      checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(16 + k) || rf_wdata !== 32'(32'hB00 + k)) begin
        errors++; $display("FAIL pp_order k%0d got wen=%b waddr=%0d wdata=%h want 1/%0d/%h", k, rf_wen, rf_waddr, rf_wdata, 16 + k, 32'hB00 + k);
      end
      $display("push_pop k%0d: wen=%b waddr=%0d wdata=%h", k, rf_wen, rf_waddr, rf_wdata);
      step();
    end
    checks++; if (rf_wen !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL pp_after_drain got wen=%b busy=%b want 0/0", rf_wen, busy);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_rd = 26; alu_data = 32'h26;
      mem_valid = 1; mem_rd = 5'(1 + c); mem_data = 32'(32'hC00 + c);
      step();
    end
    idle_inputs();
    checks++; if (busy !== 1'b1 || rf_wen !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got busy=%b wen=%b want 1/1", busy, rf_wen);
    end
    #2 rst = 1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL rstmid_mem_ready got %b want 1", mem_ready); end
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rstmid_wen got %b want 0", rf_wen); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rstmid_alu_ready got %b want 1", alu_ready); end
    $display("reset_mid: busy=%b mem_ready=%b wen=%b", busy, mem_ready, rf_wen);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (rf_wen !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rstmid_flushed k%0d got wen=%b busy=%b waddr=%0d want 0/0", k, rf_wen, busy, rf_waddr);
      end
    end
    $display("reset_mid: no writes after release");
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_alu_basic();
    test_alu_x0();
    test_starvation();
    test_full();
    test_push_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback initiator for the RISC-V core's register file. It merges register results from two producers, the ALU path and the memory (load) response path, into the register file's single write port (`wen`/`waddr`/`wdata`). Load responses are buffered in a small FIFO, and a bounded-wait arbiter prevents the ALU from starving loads. It sits between the execute/memory stages and the register file's write port.

## Interface
Parameters:
- `XLEN`, 32, data width
- `FIFO_DEPTH`, 4, load-response FIFO entries (power of two, ≥2)
- `MAX_WAIT`, 3, maximum consecutive cycles a non-empty FIFO head may lose arbitration (≥1)

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `alu_valid` in 1: ALU result present
- `alu_rd` in 5: destination register
- `alu_data` in XLEN: result
- `alu_ready` out 1: ALU result accepted this cycle when `alu_valid & alu_ready`
- `mem_valid` in 1: load response present
- `mem_rd` in 5: destination register
- `mem_data` in XLEN: load data
- `mem_ready` out 1: FIFO not full
- `rf_wen` out 1: register file write enable
- `rf_waddr` out 5: register file write address
- `rf_wdata` out XLEN: register file write data
- `busy` out 1: FIFO non-empty

## Operation
- **Load push.** Occurs on `mem_valid & mem_ready`. `mem_ready = !full`, derived from registered occupancy only. There is no pass-through when full.
- **Arbitration.**
  - Define `mem_prio = !empty & (wait_cnt == MAX_WAIT | full)`.
  - `alu_ready = !mem_prio`. It does not depend on `alu_valid`.
  - Grant order: if `mem_prio`, pop the FIFO. Else if `alu_valid`, grant the ALU. Else if `!empty`, pop the FIFO. Else idle.
- **`wait_cnt`.**
  - Resets to 0 on any pop or when the FIFO is empty.
  - Otherwise increments at the end of each cycle where the FIFO is non-empty and not popped.
  - Saturates at `MAX_WAIT`.
- **Output register.** Updated on every clock edge:
  - `rf_wen <= granted & (rd != 0)`.
  - `rf_waddr`/`rf_wdata` take the granted `rd`/`data`, or 0 when idle.
- **x0 writes.** Accepted and consumed, but never asserted on `rf_wen`.
- **Ordering.** Order within a source is preserved. Order across sources follows arbitration. RAW/WAW hazards on the same `rd` are the pipeline's responsibility.
- **Simultaneous push and pop.** Occupancy is unchanged. This is legal at any occupancy except full, where a push is impossible.
- **Reset.**
  - Asserting `rst`, including mid-operation, flushes the FIFO immediately and asynchronously.
  - After reset: `wait_cnt=0`, `rf_wen=0`, `rf_waddr=0`, `rf_wdata=0`, `busy=0`, `mem_ready=1`, `alu_ready=1`.
  - Pending entries are discarded and never written.

## Timing
- ALU accepted in cycle N → `rf_wen` high in cycle N+1.
- Load pushed in cycle N → earliest pop in N+1 → earliest write in N+2.
- Worst-case wait for the FIFO head under continuous ALU traffic is `MAX_WAIT` cycles after it becomes head.
- Throughput: one register write per cycle.
- `busy` and `mem_ready` are functions of registered state only.

## Structure
- Package `wb_pkg` contains:
  - `REG_ADDR_W=5`
  - typedef `wb_req_t` as a packed struct `{rd, data}`
  - enum `wb_src_e` with values `{SRC_NONE, SRC_ALU, SRC_MEM}` for the grant
- Sub-module `wb_fifo`: a synchronous FIFO of `wb_req_t`.
  - Depth `FIFO_DEPTH`.
  - Wrap-around pointers plus an occupancy count.
  - Outputs `full`/`empty` and a head peek.
  - Asynchronous active-high reset.
- The top level holds the arbiter, `wait_cnt`, and the output register.

## Test plan
- ALU only, `rd=5`, `data=0xDEADBEEF`, in cycle 0 → cycle 1 shows `rf_wen=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`, then `rf_wen=0`.
- ALU `rd=0`, `data=0x1234` → `alu_ready=1` and `rf_wen` stays 0.
- Starvation, `MAX_WAIT=3`: `alu_valid` held high with distinct `rd`, plus one load `rd=7`, `data=0xCAFE0007`, pushed in cycle 0 → ALU writes for cycles 1–3. In cycle 4, `alu_ready=0` and the load pops. In cycle 5, `rf_waddr=7`, `rf_wdata=0xCAFE0007`.
- Full FIFO: with the ALU busy, push 4 loads → `mem_ready=0` after the 4th push and `alu_ready=0` while full. The loads drain in push order, one per cycle, and `mem_ready` rises after the first pop.
- Simultaneous push and pop at occupancy 3 with the ALU idle → occupancy stays 3, `mem_ready` stays 1, and the writes appear in FIFO order.
- Reset mid-operation: 3 loads buffered, then assert `rst` asynchronously between edges → `busy=0`, `mem_ready=1`, `rf_wen=0` immediately. No buffered entry is written after release.
